// File: rtl/rr_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mem_port_arbiter
// Description : Round-robin arbiter sharing one memory request port among
//               1<<LG_N requesters, holding each grant for a whole
//               request/response transaction.  Optional macro
//               ARB_WAIT_CNT_EN enables the starved-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mem_port_arbiter #(
    parameter int LG_N   = 2,
    parameter int WAIT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [(1<<LG_N)-1:0]   req_valid,
    output logic [(1<<LG_N)-1:0]   req_ready,
    output logic                   mem_req_valid,
    output logic [LG_N-1:0]        mem_req_id,
    input  logic                   mem_req_ready,
    input  logic                   mem_rsp_valid,
    output logic [(1<<LG_N)-1:0]   rsp_valid,
    output logic                   busy,
    output logic                   protocol_err,
    output logic [WAIT_W-1:0]      wait_cycles
);

    localparam int c_num_req = 1 << LG_N;
    localparam logic [c_num_req-1:0] c_one = {{(c_num_req-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [LG_N-1:0] r_ptr;
    logic [LG_N-1:0] r_id;
    logic            r_protocol_err;

    logic [LG_N-1:0] w_winner;
    logic [LG_N-1:0] w_idx;
    logic            w_found;
    logic            w_rsp_route;
    logic            w_accept_pt;
    logic            w_accept;
    logic            w_unexpected_rsp;

    // Rotating-priority scan starting at r_ptr; LG_N-bit addition wraps mod N.
    always_comb begin
        w_winner = r_ptr;
        w_idx    = '0;
        w_found  = 1'b0;
        for (int k = 0; k < c_num_req; k++) begin
            w_idx = r_ptr + LG_N'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    // A response completes the transaction in WAIT, or in ISSUE when the
    // request is accepted in the same cycle (zero-latency memory).
    assign w_rsp_route = !rst && mem_rsp_valid &&
                         ((r_state == c_st_wait) ||
                          ((r_state == c_st_issue) && mem_req_ready));

    assign w_accept_pt = !rst && ((r_state == c_st_idle) || w_rsp_route);
    assign w_accept    = w_accept_pt && w_found;

    assign w_unexpected_rsp = mem_rsp_valid &&
                              ((r_state == c_st_idle) ||
                               ((r_state == c_st_issue) && !mem_req_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_ptr          <= '0;
            r_id           <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_id  <= w_winner;
                r_ptr <= w_winner + LG_N'(1);
            end
            if (w_unexpected_rsp) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                w_next_state = w_accept ? c_st_issue : c_st_idle;
            end
            c_st_issue: begin
                if (mem_req_ready) begin
                    if (mem_rsp_valid) begin
                        w_next_state = w_accept ? c_st_issue : c_st_idle;
                    end else begin
                        w_next_state = c_st_wait;
                    end
                end
            end
            c_st_wait: begin
                if (mem_rsp_valid) begin
                    w_next_state = w_accept ? c_st_issue : c_st_idle;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_comb begin
        req_ready     = w_accept ? (c_one << w_winner) : '0;
        rsp_valid     = w_rsp_route ? (c_one << r_id) : '0;
        mem_req_valid = !rst && (r_state == c_st_issue);
        mem_req_id    = r_id;
        busy          = !rst && (r_state != c_st_idle);
        protocol_err  = r_protocol_err;
    end

`ifdef ARB_WAIT_CNT_EN
    logic [c_num_req-1:0] w_starved;
    logic [LG_N:0]        w_pop;
    logic [WAIT_W:0]      w_sum;
    logic [WAIT_W-1:0]    r_wait;

    assign w_starved = req_valid & ~req_ready;

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < c_num_req; k++) begin
            w_pop = w_pop + {{LG_N{1'b0}}, w_starved[k]};
        end
    end

    // One extra bit catches overflow so the counter can pin at all-ones.
    assign w_sum = {1'b0, r_wait} + {{(WAIT_W-LG_N){1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if (w_sum[WAIT_W]) begin
            r_wait <= '1;
        end else begin
            r_wait <= w_sum[WAIT_W-1:0];
        end
    end

    assign wait_cycles = r_wait;
`else
    assign wait_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mem_port_arbiter
// Description : Directed self-checking bench for rr_mem_port_arbiter (N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic        mem_req_valid;
    logic [1:0]  mem_req_id;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [3:0]  rsp_valid;
    logic        busy;
    logic        protocol_err;
    logic [31:0] wait_cycles;

    int tests_run;
    int tests_failed;

    rr_mem_port_arbiter #(.LG_N(2), .WAIT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_id    (mem_req_id),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .rsp_valid     (rsp_valid),
        .busy          (busy),
        .protocol_err  (protocol_err),
        .wait_cycles   (wait_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (req_ready !== 4'b0000) begin
                tests_failed++; $display("FAIL reset_req_ready cyc%0d: got %b expected 0000", c, req_ready);
            end
            tests_run++;
            if (mem_req_valid !== 1'b0) begin
                tests_failed++; $display("FAIL reset_mem_req_valid cyc%0d: got %b expected 0", c, mem_req_valid);
            end
            tests_run++;
            if (busy !== 1'b0) begin
                tests_failed++; $display("FAIL reset_busy cyc%0d: got %b expected 0", c, busy);
            end
            tick();
        end
        tests_run++;
        if (protocol_err !== 1'b0 || wait_cycles !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_regs: got err=%b wait=%0d expected err=0 wait=0", protocol_err, wait_cycles);
        end
        rst = 1'b0; req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_rotation();
        logic [1:0] g [0:4];
        g[0] = 2'd0; g[1] = 2'd1; g[2] = 2'd2; g[3] = 2'd3; g[4] = 2'd0;
        req_valid = 4'b1111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL rot_first_grant: got %b expected 0001", req_ready);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
            #1;
            tests_run++;
            if (mem_req_valid !== 1'b1 || mem_req_id !== g[i]) begin
                tests_failed++;
                $display("FAIL rot_issue%0d: got valid=%b id=%0d expected valid=1 id=%0d", i, mem_req_valid, mem_req_id, g[i]);
            end
            tick();
            mem_req_ready = 1'b0;
            #1;
            tests_run++;
            if (req_ready !== 4'b0000 || mem_req_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rot_wait%0d: got ready=%b mvalid=%b expected 0000 0", i, req_ready, mem_req_valid);
            end
            tick();
            mem_rsp_valid = 1'b1;
            if (i == 4) req_valid = 4'b0000;
            #1;
            tests_run++;
            if (rsp_valid !== (4'b0001 << g[i])) begin
                tests_failed++; $display("FAIL rot_rsp%0d: got %b expected %b", i, rsp_valid, 4'b0001 << g[i]);
            end
            tests_run++;
            if (req_ready !== ((i < 4) ? (4'b0001 << g[(i < 4) ? i + 1 : 0]) : 4'b0000)) begin
                tests_failed++; $display("FAIL rot_b2b_grant%0d: got %b", i, req_ready);
            end
            tick();
        end
        mem_rsp_valid = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL rot_idle_after: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_skip_wrap();
        // r_ptr is 1 here; grant 2 moves it to 3.
        req_valid = 4'b0100;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++; $display("FAIL skip_setup_grant: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; req_valid = 4'b0101;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL skip_wrap_grant0: got %b expected 0001", req_ready);
        end
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100 || rsp_valid !== 4'b0001) begin
            tests_failed++;
            $display("FAIL skip_grant2: got ready=%b rsp=%b expected 0100 0001", req_ready, rsp_valid);
        end
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1011; mem_req_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests_run++;
            if (mem_req_valid !== 1'b1 || mem_req_id !== 2'd2) begin
                tests_failed++;
                $display("FAIL bp_stable cyc%0d: got valid=%b id=%0d expected 1 2", c, mem_req_valid, mem_req_id);
            end
            tests_run++;
            if (req_ready !== 4'b0000) begin
                tests_failed++; $display("FAIL bp_no_ready cyc%0d: got %b expected 0000", c, req_ready);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic test_zero_latency();
        // WAIT, owner 2, r_ptr 3: respond and grant 3 back-to-back.
        req_valid = 4'b1000; mem_rsp_valid = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 4'b0100 || req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL zl_setup: got rsp=%b ready=%b expected 0100 1000", rsp_valid, req_ready);
        end
        tick();
        req_valid = 4'b0010; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 4'b1000 || req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL zl_same_cycle: got rsp=%b ready=%b expected 1000 0010", rsp_valid, req_ready);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_id !== 2'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL zl_next_issue: got valid=%b id=%0d busy=%b expected 1 1 1", mem_req_valid, mem_req_id, busy);
        end
        #1;
        tests_run++;
        if (rsp_valid !== 4'b0010 || req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL zl_last_rsp: got rsp=%b ready=%b expected 0010 0000", rsp_valid, req_ready);
        end
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || protocol_err !== 1'b0) begin
            tests_failed++; $display("FAIL zl_idle: got busy=%b err=%b expected 0 0", busy, protocol_err);
        end
    endtask

    task automatic test_reset_abort();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; rst = 1'b1; mem_rsp_valid = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 4'b0000) begin
            tests_failed++; $display("FAIL abort_no_rsp: got %b expected 0000", rsp_valid);
        end
        tick();
        rst = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || protocol_err !== 1'b0) begin
            tests_failed++; $display("FAIL abort_idle: got busy=%b err=%b expected 0 0", busy, protocol_err);
        end
        tick();
    endtask

    task automatic test_protocol_err();
        mem_rsp_valid = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 4'b0000) begin
            tests_failed++; $display("FAIL perr_no_route: got %b expected 0000", rsp_valid);
        end
        tick();
        mem_rsp_valid = 1'b0;
        tests_run++;
        if (protocol_err !== 1'b1) begin
            tests_failed++; $display("FAIL perr_set: got %b expected 1", protocol_err);
        end
        tick(); tick(); tick();
        tests_run++;
        if (protocol_err !== 1'b1) begin
            tests_failed++; $display("FAIL perr_sticky: got %b expected 1", protocol_err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (protocol_err !== 1'b0) begin
            tests_failed++; $display("FAIL perr_cleared: got %b expected 0", protocol_err);
        end
    endtask

    task automatic test_wait_cnt();
`ifdef ARB_WAIT_CNT_EN
        logic [31:0] w0;
        req_valid = 4'b0001;
        tick();
        w0 = wait_cycles;
        req_valid = 4'b1110; mem_req_ready = 1'b0;
        tick(); tick(); tick(); tick();
        req_valid = 4'b0000;
        tests_run++;
        if (wait_cycles - w0 !== 32'd12) begin
            tests_failed++; $display("FAIL wait_cnt_delta: got %0d expected 12", wait_cycles - w0);
        end
`else
        req_valid = 4'b1110;
        tick(); tick();
        req_valid = 4'b0000;
        tests_run++;
        if (wait_cycles !== 32'd0) begin
            tests_failed++; $display("FAIL wait_cnt_tied: got %0d expected 0", wait_cycles);
        end
`endif
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b1; req_valid = 4'b0000; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_backpressure();
        test_zero_latency();
        test_reset_abort();
        test_protocol_err();
        test_wait_cnt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
